// File: rtl/irq_priority_encoder.sv
// 68000-style interrupt priority encoder: synchronises seven active-low requests,
// encodes the highest pending level onto nIPL and holds it off after an acknowledge.
// Define IRQ_EDGE_LATCH_EN for edge-latched requests cleared by IACK; default is level-sensitive.
module irq_priority_encoder (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] nIRQ,
  input  logic       IACK,
  input  logic [2:0] IACK_LEVEL,
  output logic [2:0] nIPL,
  output logic [6:0] PENDING,
  output logic       IRQ_ACTIVE,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    ACK_HOLD = 2'd2
  } state_t;

  logic [6:0] r_s1;
  logic [6:0] r_s2;
  logic [6:0] r_pending;
  logic [2:0] r_cand;
  logic [2:0] r_nipl;
  logic       r_active;
  logic       r_hold;
  state_t     r_state;

  logic [6:0] w_pending_nxt;
  logic [2:0] w_level;
  logic       w_ack;
  logic       w_load;
  state_t     w_state_nxt;
  logic [2:0] w_nipl_nxt;
  logic       w_hold_nxt;

  // An acknowledge naming level 0 is not a real acknowledge and is ignored.
  assign w_ack  = IACK && (IACK_LEVEL != 3'd0);
  assign w_load = (r_cand == w_level);

`ifdef IRQ_EDGE_LATCH_EN
  logic [6:0] r_prev;
  logic [6:0] w_fall;
  logic [6:0] w_clr;

  assign w_fall = r_prev & ~r_s2;

  always_comb begin
    w_clr = 7'd0;
    if (w_ack) w_clr[IACK_LEVEL - 3'd1] = 1'b1;
    // A new falling edge wins over a same-edge acknowledge clear.
    w_pending_nxt = (r_pending & ~w_clr) | w_fall;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_prev <= 7'h7F;
    else       r_prev <= r_s2;
  end
`else
  assign w_pending_nxt = ~r_s2;
`endif

  always_comb begin
    w_level = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (r_pending[k]) w_level = 3'(k + 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_nipl_nxt  = r_nipl;
    w_hold_nxt  = r_hold;
    if (w_ack) begin
      w_state_nxt = ACK_HOLD;
      w_nipl_nxt  = 3'b111;
      w_hold_nxt  = 1'b1;
    end else begin
      case (r_state)
        ACK_HOLD: begin
          if (r_hold) begin
            w_hold_nxt = 1'b0;
          end else if (w_load && (w_level != 3'd0)) begin
            w_state_nxt = ACTIVE;
            w_nipl_nxt  = ~w_level;
          end else begin
            w_state_nxt = IDLE;
            w_nipl_nxt  = 3'b111;
          end
        end
        default: begin
          // Only a level that has been stable for two cycles reaches the CPU.
          if (w_load) begin
            w_nipl_nxt  = ~w_level;
            w_state_nxt = (w_level != 3'd0) ? ACTIVE : IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1      <= 7'h7F;
      r_s2      <= 7'h7F;
      r_pending <= 7'd0;
      r_cand    <= 3'd0;
      r_nipl    <= 3'b111;
      r_active  <= 1'b0;
      r_hold    <= 1'b0;
      r_state   <= IDLE;
    end else begin
      r_s1      <= nIRQ;
      r_s2      <= r_s1;
      r_pending <= w_pending_nxt;
      r_cand    <= w_level;
      r_nipl    <= w_nipl_nxt;
      r_active  <= (w_nipl_nxt != 3'b111);
      r_hold    <= w_hold_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign nIPL       = r_nipl;
  assign PENDING    = r_pending;
  assign IRQ_ACTIVE = r_active;
  assign o_state    = r_state;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Self-checking bench for irq_priority_encoder: latency, acknowledge hold,
// reset behaviour and a table of steady-state request patterns.
module tb_irq_priority_encoder;

  logic       CLK;
  logic       RESET;
  logic [6:0] nIRQ;
  logic       IACK;
  logic [2:0] IACK_LEVEL;
  logic [2:0] nIPL;
  logic [6:0] PENDING;
  logic       IRQ_ACTIVE;
  logic [1:0] o_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] nirq;
    logic [6:0] pend;
    logic [2:0] nipl;
    logic       act;
  } vec_t;

  vec_t        vecs[9];
  logic [10:0] exp_q[$];

  irq_priority_encoder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .nIRQ       (nIRQ),
    .IACK       (IACK),
    .IACK_LEVEL (IACK_LEVEL),
    .nIPL       (nIPL),
    .PENDING    (PENDING),
    .IRQ_ACTIVE (IRQ_ACTIVE),
    .o_state    (o_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_iack(input logic [2:0] lvl);
    IACK       = 1'b1;
    IACK_LEVEL = lvl;
    tick();
    IACK       = 1'b0;
    IACK_LEVEL = 3'd0;
  endtask

  initial begin
    RESET      = 1'b1;
    nIRQ       = 7'h7F;
    IACK       = 1'b0;
    IACK_LEVEL = 3'd0;
    vecs[0] = '{7'h7F, 7'h00, 3'b111, 1'b0};
    vecs[1] = '{7'h77, 7'h08, 3'b011, 1'b1};
    vecs[2] = '{7'h5D, 7'h22, 3'b001, 1'b1};
    vecs[3] = '{7'h7D, 7'h02, 3'b101, 1'b1};
    vecs[4] = '{7'h3F, 7'h40, 3'b000, 1'b1};
    vecs[5] = '{7'h7E, 7'h01, 3'b110, 1'b1};
    vecs[6] = '{7'h00, 7'h7F, 3'b000, 1'b1};
    vecs[7] = '{7'h6F, 7'h10, 3'b010, 1'b1};
    vecs[8] = '{7'h7F, 7'h00, 3'b111, 1'b0};

    // Reset state, and nothing moves on release.
    @(negedge CLK);
    @(negedge CLK);
    check("rst_nipl", 32'(nIPL), 32'h7);
    check("rst_pending", 32'(PENDING), 32'h0);
    check("rst_active", 32'(IRQ_ACTIVE), 32'h0);
    check("rst_state", 32'(o_state), 32'h0);
    RESET = 1'b0;
    ticks(4);
    check("rel_nipl", 32'(nIPL), 32'h7);
    check("rel_pending", 32'(PENDING), 32'h0);

    // Level 4 latency: PENDING after edge 3, nIPL after edge 5.
    nIRQ = 7'h77;
    ticks(2);
    check("lat_e2_pending", 32'(PENDING), 32'h00);
    tick();
    check("lat_e3_pending", 32'(PENDING), 32'h08);
    check("lat_e3_nipl", 32'(nIPL), 32'h7);
    tick();
    check("lat_e4_nipl", 32'(nIPL), 32'h7);
    tick();
    check("lat_e5_nipl", 32'(nIPL), 32'h3);
    check("lat_e5_active", 32'(IRQ_ACTIVE), 32'h1);
    check("lat_e5_state", 32'(o_state), 32'h1);

`ifdef IRQ_EDGE_LATCH_EN
    // Acknowledge clears the latched level-4 request and the block goes idle.
    pulse_iack(3'd4);
    check("ack4_pending", 32'(PENDING), 32'h00);
    check("ack4_nipl_h0", 32'(nIPL), 32'h7);
    tick();
    check("ack4_nipl_h1", 32'(nIPL), 32'h7);
    tick();
    check("ack4_nipl_exit", 32'(nIPL), 32'h7);
    check("ack4_state", 32'(o_state), 32'h0);
    check("ack4_active", 32'(IRQ_ACTIVE), 32'h0);

    // Level 2 stays latched after release.
    nIRQ = 7'h7D;
    ticks(6);
    check("l2_nipl", 32'(nIPL), 32'h5);
    nIRQ = 7'h7F;
    ticks(6);
    check("l2_latched_pending", 32'(PENDING), 32'h02);
    check("l2_latched_nipl", 32'(nIPL), 32'h5);

    // New falling edge on the same edge as the acknowledge: the set wins.
    nIRQ = 7'h7D;
    ticks(2);
    pulse_iack(3'd2);
    check("setwin_pending", 32'(PENDING), 32'h02);
    check("setwin_nipl_h0", 32'(nIPL), 32'h7);
    tick();
    check("setwin_nipl_h1", 32'(nIPL), 32'h7);
    tick();
    check("setwin_nipl_exit", 32'(nIPL), 32'h5);
    check("setwin_state", 32'(o_state), 32'h1);
`else
    // Acknowledge holds nIPL off for two cycles but leaves PENDING alone.
    pulse_iack(3'd4);
    check("ack_nipl_h0", 32'(nIPL), 32'h7);
    check("ack_active_h0", 32'(IRQ_ACTIVE), 32'h0);
    check("ack_pending", 32'(PENDING), 32'h08);
    check("ack_state", 32'(o_state), 32'h2);
    tick();
    check("ack_nipl_h1", 32'(nIPL), 32'h7);
    tick();
    check("ack_nipl_exit", 32'(nIPL), 32'h3);
    check("ack_active_exit", 32'(IRQ_ACTIVE), 32'h1);

    // Level-0 acknowledge is ignored.
    pulse_iack(3'd0);
    check("ack0_nipl", 32'(nIPL), 32'h3);
    check("ack0_state", 32'(o_state), 32'h1);

    // Back-to-back acknowledges restart the hold; second names a non-pending level.
    IACK       = 1'b1;
    IACK_LEVEL = 3'd4;
    tick();
    IACK_LEVEL = 3'd3;
    tick();
    IACK       = 1'b0;
    IACK_LEVEL = 3'd0;
    check("restart_pending", 32'(PENDING), 32'h08);
    tick();
    check("restart_nipl_hold", 32'(nIPL), 32'h7);
    tick();
    check("restart_nipl_exit", 32'(nIPL), 32'h3);

    // Steady-state table through the scoreboard queue.
    for (int v = 0; v < 9; v++) begin
      logic [10:0] e;
      nIRQ = vecs[v].nirq;
      exp_q.push_back({vecs[v].pend, vecs[v].nipl, vecs[v].act});
      ticks(8);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_pending", v), 32'(PENDING), 32'(e[10:4]));
      check($sformatf("vec%0d_nipl", v), 32'(nIPL), 32'(e[3:1]));
      check($sformatf("vec%0d_active", v), 32'(IRQ_ACTIVE), 32'(e[0]));
    end
`endif

    // Level 5 active, asynchronous reset pulse, then recovery from fresh samples.
    nIRQ = 7'h6F;
    ticks(8);
    check("l5_nipl", 32'(nIPL), 32'h2);
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst_nipl", 32'(nIPL), 32'h7);
    check("async_rst_pending", 32'(PENDING), 32'h00);
    check("async_rst_active", 32'(IRQ_ACTIVE), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    ticks(3);
    check("rec_e3_pending", 32'(PENDING), 32'h10);
    tick();
    check("rec_e4_nipl", 32'(nIPL), 32'h7);
    tick();
    check("rec_e5_nipl", 32'(nIPL), 32'h2);
    check("rec_e5_active", 32'(IRQ_ACTIVE), 32'h1);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_priority_encoder.md
IRQ_PRIORITY_ENCODER -- requirements
Module: irq_priority_encoder

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port nIRQ, input, 7, active-low interrupt requests; bit k carries level k+1.
REQ-004 SHALL have port IACK, input, 1, one-cycle-high CPU interrupt-acknowledge strobe.
REQ-005 SHALL have port IACK_LEVEL, input, 3, level being acknowledged (CPU A3..A1), sampled only when IACK=1.
REQ-006 SHALL have port nIPL, output, 3, registered active-low encoded interrupt level to the 68000.
REQ-007 SHALL have port PENDING, output, 7, registered pending-request vector, bit k = level k+1.
REQ-008 SHALL have port IRQ_ACTIVE, output, 1, registered, high whenever nIPL != 3'b111.

Function
REQ-009 SHALL pass each nIRQ bit through a two-flop synchroniser (s1, s2) before use.
REQ-010 SHALL update PENDING on the edge after s2 changes; pending latency is 3 edges from first low sample.
REQ-011 SHALL priority-encode PENDING combinationally to level L: highest set bit index+1, or 0 if none.
REQ-012 SHALL register L into candidate register CAND every edge.
REQ-013 SHALL load nIPL with ~L only on an edge where CAND equals L (level stable two consecutive cycles).
REQ-014 Total latency: nIRQ first sampled low at edge 1 -> nIPL shows new level after edge 5, absent higher-priority activity.
REQ-015 SHALL implement states IDLE (nIPL=111), ACTIVE (nIPL=~level, level != 0), ACK_HOLD.
REQ-016 IDLE -> ACTIVE when the REQ-013 load condition yields L != 0.
REQ-017 ACTIVE -> IDLE when the REQ-013 load condition yields L = 0; ACTIVE -> ACTIVE on stable change to another non-zero level, nIPL updating in place.
REQ-018 Any state, IACK=1 -> ACK_HOLD; nIPL forced 111 on that edge and held for 2 cycles.
REQ-019 ACK_HOLD exit after 2 cycles: -> ACTIVE with nIPL=~L if CAND equals L != 0, else -> IDLE.
REQ-020 IACK during ACK_HOLD SHALL restart the 2-cycle hold.
REQ-021 IACK with IACK_LEVEL=0 SHALL be ignored entirely, including the state change.
REQ-022 IACK_LEVEL naming a non-pending level SHALL leave PENDING unchanged; REQ-018 still applies.
REQ-023 Level 7 SHALL be encoded like all other levels; no masking inside this block.

Reset
REQ-024 RESET high SHALL asynchronously force s1, s2 and previous-sample flops to 1 (inactive).
REQ-025 RESET high SHALL force PENDING=0, CAND=0, nIPL=3'b111, IRQ_ACTIVE=0 and state IDLE.
REQ-026 Reset asserted mid-ACTIVE or mid-ACK_HOLD SHALL discard all pending requests; after release only requests sampled afresh are seen.

Configuration
REQ-027 Macro IRQ_EDGE_LATCH_EN defined: PENDING bit sets on s2 falling edge (1->0 vs previous sample), clears only on IACK with matching IACK_LEVEL.
REQ-028 With the macro, same-edge set and IACK clear on one bit: set SHALL win.
REQ-029 Macro undefined: PENDING bit = registered ~s2 (level-sensitive); IACK SHALL NOT modify PENDING; REQ-018 still applies.

Verification
REQ-030 Reset, nIRQ=7'h7F -> nIPL=111, PENDING=0, IRQ_ACTIVE=0; reset release changes nothing.
REQ-031 nIRQ[3] low from edge 1 -> PENDING=7'h08 after edge 3, nIPL=3'b011 after edge 5, IRQ_ACTIVE=1.
REQ-032 nIRQ[1] and nIRQ[5] low together -> nIPL=3'b001 (level 6); nIRQ[5] released (level mode) -> nIPL=3'b101 (level 2) after stabilisation.
REQ-033 Edge mode, level 4 pending, IACK=1 with IACK_LEVEL=4 -> PENDING bit 3 cleared, nIPL=111 for 2 cycles, then IDLE.
REQ-034 Edge mode, level 2 pending: IACK_LEVEL=2 on the same edge as a new level-2 falling edge -> PENDING bit 1 stays set; nIPL returns to 3'b101 after ACK_HOLD.
REQ-035 Level 5 active, RESET pulsed for 1 cycle -> nIPL=111 immediately (asynchronous); nIRQ[4] still low -> nIPL=3'b010 again 5 edges after release.
